// File: rtl/im_loader_pkg.sv
// Shared constants and state encoding for the instruction-memory loader.
// IM_LENGTH must match the instruction memory depth.
package im_loader_pkg;

    localparam int IM_LENGTH     = 1024;
    localparam int IM_ADDR_W     = 10;
    localparam bit IM_BIG_ENDIAN = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } ld_state_t;

endpackage

// File: rtl/im_word_packer.sv
// Packs four accepted bytes into one 32-bit word.
// Ports: clk, rst_n, clear (restart packing), accept (byte taken this cycle),
// byte_data; word_next (word including this byte), word_full (4th byte now).
module im_word_packer
    import im_loader_pkg::*;
#(
    parameter bit BIG_ENDIAN = IM_BIG_ENDIAN
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        accept,
    input  logic [7:0]  byte_data,
    output logic [31:0] word_next,
    output logic        word_full
);

    logic [1:0]  byte_cnt;
    logic [31:0] shreg;

    // Big endian: first byte migrates up to [31:24] after four shifts.
    // Little endian: first byte migrates down to [7:0].
    assign word_next = BIG_ENDIAN ? {shreg[23:0], byte_data}
                                  : {byte_data, shreg[31:8]};

    assign word_full = accept && (byte_cnt == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt <= 2'd0;
            shreg    <= 32'd0;
        end else if (clear) begin
            byte_cnt <= 2'd0;
            shreg    <= 32'd0;
        end else if (accept) begin
            byte_cnt <= byte_cnt + 2'd1;
            shreg    <= word_next;
        end
    end

endmodule

// File: rtl/im_loader.sv
// Loads a host byte stream into instruction memory and holds the CPU meanwhile.
// Ports: start/len_words begin a load; byte_valid/byte_data/byte_ready host link;
// im_we/im_addr/im_wdata memory write; cpu_hold, busy, done, err status.
module im_loader
    import im_loader_pkg::*;
#(
    parameter int ADDR_W     = IM_ADDR_W,
    parameter int DEPTH      = IM_LENGTH,
    parameter bit BIG_ENDIAN = IM_BIG_ENDIAN
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [10:0]       len_words,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [10:0] DEPTH_L = 11'(DEPTH);

    ld_state_t   state_q;
    ld_state_t   state_d;
    logic [10:0] word_cnt;
    logic [10:0] word_cnt_inc;
    logic [10:0] len_q;
    logic        len_ok;
    logic        idle_like;
    logic        start_ok;
    logic        start_bad;
    logic        accept;
    logic        last_word;
    logic [31:0] word_next;
    logic        word_full;

    assign byte_ready   = (state_q == ST_RECV);
    assign im_we        = (state_q == ST_WRITE);
    assign accept       = byte_valid && byte_ready;
    assign len_ok       = (len_words != 11'd0) && (len_words <= DEPTH_L);
    assign idle_like    = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign start_ok     = start && idle_like && len_ok;
    assign start_bad    = start && idle_like && !len_ok;
    assign word_cnt_inc = word_cnt + 11'd1;
    assign last_word    = (word_cnt_inc == len_q);

    im_word_packer #(
        .BIG_ENDIAN(BIG_ENDIAN)
    ) u_packer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (start_ok),
        .accept   (accept),
        .byte_data(byte_data),
        .word_next(word_next),
        .word_full(word_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_ok) state_d = ST_RECV;
            end
            ST_RECV: begin
                if (word_full) state_d = ST_WRITE;
            end
            ST_WRITE: begin
                state_d = last_word ? ST_DONE : ST_RECV;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt <= 11'd0;
            len_q    <= 11'd0;
            im_addr  <= '0;
            im_wdata <= 32'd0;
            cpu_hold <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            // A rejected start leaves the FSM and cpu_hold untouched.
            if (start_bad) begin
                err  <= 1'b1;
                done <= 1'b0;
            end
            if (start_ok) begin
                word_cnt <= 11'd0;
                len_q    <= len_words;
                im_addr  <= '0;
                cpu_hold <= 1'b1;
                busy     <= 1'b1;
                done     <= 1'b0;
                err      <= 1'b0;
            end
            if (state_q == ST_RECV && word_full) begin
                im_wdata <= word_next;
            end
            if (state_q == ST_WRITE) begin
                word_cnt <= word_cnt_inc;
                if (last_word) begin
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    cpu_hold <= 1'b0;
                end else begin
                    im_addr <= im_addr + ADDR_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_im_loader.sv
// Randomized self-checking bench for im_loader, big and little endian
// instances driven in lockstep and checked against a byte-queue model.
module tb_im_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [10:0] len_words = 11'd0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'd0;

    logic        ready_b, we_b, hold_b, busy_b, done_b, err_b;
    logic [9:0]  addr_b;
    logic [31:0] wdata_b;
    logic        ready_l, we_l, hold_l, busy_l, done_l, err_l;
    logic [9:0]  addr_l;
    logic [31:0] wdata_l;

    always #5 clk = ~clk;

    im_loader #(.BIG_ENDIAN(1'b1)) dut_be (
        .clk(clk), .rst_n(rst_n), .start(start), .len_words(len_words),
        .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(ready_b), .im_we(we_b), .im_addr(addr_b),
        .im_wdata(wdata_b), .cpu_hold(hold_b), .busy(busy_b),
        .done(done_b), .err(err_b)
    );

    im_loader #(.BIG_ENDIAN(1'b0)) dut_le (
        .clk(clk), .rst_n(rst_n), .start(start), .len_words(len_words),
        .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(ready_l), .im_we(we_l), .im_addr(addr_l),
        .im_wdata(wdata_l), .cpu_hold(hold_l), .busy(busy_l),
        .done(done_l), .err(err_l)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    logic [7:0]  tx_q[$];
    logic [9:0]  wa_b[$], wa_l[$];
    logic [31:0] wd_b[$], wd_l[$];
    int          acc_cnt = 0;

    always @(posedge clk) if (byte_valid && ready_b) acc_cnt++;

    always @(negedge clk) begin
        if (we_b) begin wa_b.push_back(addr_b); wd_b.push_back(wdata_b); end
        if (we_l) begin wa_l.push_back(addr_l); wd_l.push_back(wdata_l); end
    end

    task automatic clear_log();
        wa_b.delete(); wd_b.delete(); wa_l.delete(); wd_l.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_hold_b"}, hold_b, 1);
        chk({tag, "_hold_l"}, hold_l, 1);
        chk({tag, "_outs_b"}, {ready_b, we_b, busy_b, done_b, err_b}, 0);
        chk({tag, "_outs_l"}, {ready_l, we_l, busy_l, done_l, err_l}, 0);
        chk({tag, "_addr"}, {addr_b, addr_l}, 0);
        chk({tag, "_wdata"}, {wdata_b, wdata_l}, 0);
    endtask

    // Called at a negedge; start seen on the next posedge.
    task automatic pulse_start(input int len);
        start = 1'b1;
        len_words = 11'(len);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        byte_valid = 1'b0;
        repeat (gap) @(negedge clk);
        byte_valid = 1'b1;
        byte_data = b;
        for (int t = 0; t < 50; t++) begin
            if (ready_b) begin
                @(negedge clk);
                byte_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        chk("ready_timeout", 0, 1);
        byte_valid = 1'b0;
    endtask

    // Expected words come straight from the byte order on the wire.
    function automatic logic [31:0] exp_word(input int k, input bit be);
        logic [31:0] w = 0;
        for (int j = 0; j < 4; j++) begin
            if (be) w = w + (32'(tx_q[4*k+j]) << (8 * (3 - j)));
            else    w = w + (32'(tx_q[4*k+j]) << (8 * j));
        end
        return w;
    endfunction

    task automatic run_load(input int len, input bit preset,
                            input int stall_at, input int stall_len,
                            input bit rnd, input int spur_at);
        int acc0;
        int gap;
        int n;
        clear_log();
        acc0 = acc_cnt;
        if (!preset) begin
            tx_q.delete();
            for (int i = 0; i < len * 4; i++) tx_q.push_back(8'($urandom));
        end
        pulse_start(len);
        chk("start_busy", {busy_b, busy_l}, 2'b11);
        chk("start_hold", {hold_b, hold_l}, 2'b11);
        chk("start_done_clr", {done_b, done_l}, 0);
        chk("start_err_clr", {err_b, err_l}, 0);
        for (int i = 0; i < len * 4; i++) begin
            if (i == spur_at) begin
                pulse_start(5);
                chk("spur_busy", busy_b, 1);
            end
            gap = 0;
            if (i == stall_at) gap = stall_len;
            else if (rnd && $urandom_range(0, 3) == 0) gap = $urandom_range(1, 4);
            if (i % 4 == 3) chk("no_early_we", wa_b.size(), i / 4);
            send_byte(tx_q[i], gap);
            if (i % 4 == 3) begin
                chk("we_latency", {we_b, we_l}, 2'b11);
                chk("we_addr", addr_b, i / 4);
            end
        end
        chk("hold_in_write", hold_b, 1);
        @(negedge clk);
        chk("done_after_last", {done_b, done_l}, 2'b11);
        chk("hold_released", {hold_b, hold_l}, 0);
        chk("busy_clear", {busy_b, busy_l}, 0);
        chk("ready_in_done", {ready_b, ready_l}, 0);
        chk("wr_count_be", wa_b.size(), len);
        chk("wr_count_le", wa_l.size(), len);
        chk("accepts", acc_cnt - acc0, len * 4);
        n = (wa_b.size() < len) ? wa_b.size() : len;
        for (int k = 0; k < n; k++) begin
            chk("addr_be", wa_b[k], k);
            chk("data_be", wd_b[k], exp_word(k, 1'b1));
        end
        n = (wa_l.size() < len) ? wa_l.size() : len;
        for (int k = 0; k < n; k++) begin
            chk("addr_le", wa_l[k], k);
            chk("data_le", wd_l[k], exp_word(k, 1'b0));
        end
    endtask

    task automatic err_start(input string tag, input int len, input logic hold);
        pulse_start(len);
        chk({tag, "_err"}, {err_b, err_l}, 2'b11);
        chk({tag, "_done"}, {done_b, done_l}, 0);
        chk({tag, "_hold"}, {hold_b, hold_l}, {hold, hold});
        chk({tag, "_idle"}, {busy_b, ready_b, we_b}, 0);
    endtask

    initial begin
        logic [7:0] fixed [8] = '{8'h20, 8'h08, 8'h00, 8'h05,
                                 8'h3C, 8'h01, 8'h12, 8'h34};
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Known stream from the plan: 0x20080005 / 0x3C011234 (BE).
        tx_q.delete();
        foreach (fixed[i]) tx_q.push_back(fixed[i]);
        run_load(2, 1'b1, -1, 0, 1'b0, -1);
        chk("fixed_w0_be", wd_b.size() > 0 ? wd_b[0] : 0, 32'h20080005);
        chk("fixed_w1_be", wd_b.size() > 1 ? wd_b[1] : 0, 32'h3C011234);
        chk("fixed_w0_le", wd_l.size() > 0 ? wd_l[0] : 0, 32'h05000820);

        // Error from DONE keeps cpu_hold released.
        err_start("err_done", 0, 1'b0);

        // Reset mid-RECV after two bytes.
        clear_log();
        pulse_start(3);
        send_byte(8'hA5, 0);
        send_byte(8'h5A, 0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midreset_no_we", wa_b.size() + wa_l.size(), 0);

        err_start("err_len0", 0, 1'b1);
        err_start("err_len1025", 1025, 1'b1);

        // Host stall of 10 cycles between bytes 2 and 3.
        run_load(1, 1'b0, 2, 10, 1'b0, -1);

        // start during RECV is ignored.
        run_load(2, 1'b0, -1, 0, 1'b0, 2);

        // Reload from DONE with a single word.
        run_load(1, 1'b0, -1, 0, 1'b0, -1);

        for (int r = 0; r < 4; r++)
            run_load($urandom_range(1, 8), 1'b0, -1, 0, 1'b1, -1);

        // Full-depth load.
        run_load(1024, 1'b0, -1, 0, 1'b0, -1);
        chk("last_addr", wa_b.size() > 0 ? wa_b[$] : 0, 1023);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
